myproject_mul_pipe: RTL and testbench

- Parametrised, pipelined multiplier for generated datapaths.
- Successor to the fixed combinational `mul_*` cores:
  - selectable signedness per operand;
  - configurable pipeline depth;
  - valid/ready flow control with backpressure;
  - optional multiply-accumulate mode that sums a burst of products and emits one result per burst.
- Sits between layer control and the activation/output stage wherever a product or a dot-product partial sum is needed.

---
 rtl/myproject_mul_pipe.sv | 181 ++++++++++++++++++
 tb/tb_myproject_mul_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_pipe.sv
// myproject_mul_pipe: pipelined multiplier with per-operand signedness,
// valid/ready flow control and an optional burst multiply-accumulate mode.
// Configuration macro: MUL_PIPE_SAT_EN -- when defined, dout saturates on
// overflow instead of wrapping; ovf is identical in both builds.
module myproject_mul_pipe #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 10,
    parameter int din1_WIDTH  = 8,
    parameter int dout_WIDTH  = 18,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 1,
    parameter int ACC_MODE    = 0,
    parameter int GUARD       = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_last,
    output logic                  ovf
);

    localparam int A_W  = din0_WIDTH + 1;
    localparam int B_W  = din1_WIDTH + 1;
    localparam int PW   = A_W + B_W;
    localparam int AW   = (ACC_MODE != 0) ? PW + GUARD : PW;
    localparam int CW   = ((AW > dout_WIDTH) ? AW : dout_WIDTH) + 2;
    localparam int NPRE = NUM_STAGE - 1;
    localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);

    localparam logic signed [CW-1:0] ONE = CW'(1);
    localparam logic signed [CW-1:0] HI  = RES_SIGNED ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                                      : (ONE <<< dout_WIDTH) - ONE;
    localparam logic signed [CW-1:0] LO  = RES_SIGNED ? -(ONE <<< (dout_WIDTH - 1))
                                                      : '0;

    function automatic logic signed [A_W-1:0] ext0(input logic [din0_WIDTH-1:0] v);
        return (din0_SIGNED != 0) ? {v[din0_WIDTH-1], v} : {1'b0, v};
    endfunction

    function automatic logic signed [B_W-1:0] ext1(input logic [din1_WIDTH-1:0] v);
        return (din1_SIGNED != 0) ? {v[din1_WIDTH-1], v} : {1'b0, v};
    endfunction

    logic                 en;
    logic signed [PW-1:0] p_fin;   // product entering the final stage
    logic                 v_fin;
    logic                 l_fin;
    logic signed [AW-1:0] exact;   // exact value presented to output reduction
    logic                 emit;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    generate
        if (NPRE == 0) begin : g_nopipe
            assign p_fin = PW'(ext0(din0)) * PW'(ext1(din1));
            assign v_fin = in_valid;
            assign l_fin = in_last;
        end else begin : g_pipe
            logic signed [A_W-1:0] op_a;
            logic signed [B_W-1:0] op_b;
            logic [NPRE-1:0]       vld;
            logic [NPRE-1:0]       lst;
            logic signed [PW-1:0]  p1;

            // Valid/last shift register; bubbles only move when en is high.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    vld <= '0;
                    lst <= '0;
                end else if (en) begin
                    vld[0] <= in_valid;
                    lst[0] <= in_last;
                    for (int unsigned i = 1; i < NPRE; i++) begin
                        vld[i] <= vld[i-1];
                        lst[i] <= lst[i-1];
                    end
                end
            end

            // Stage 1 captures the extended operands.
            always_ff @(posedge ap_clk) begin
                if (en) begin
                    op_a <= ext0(din0);
                    op_b <= ext1(din1);
                end
            end

            assign p1    = PW'(op_a) * PW'(op_b);
            assign v_fin = vld[NPRE-1];
            assign l_fin = lst[NPRE-1];

            if (NPRE == 1) begin : g_one
                assign p_fin = p1;
            end else begin : g_many
                logic signed [PW-1:0] prod [1:NPRE-1];

                // Product delay line for stages 2..NUM_STAGE-1.
                always_ff @(posedge ap_clk) begin
                    if (en) begin
                        prod[1] <= p1;
                        for (int unsigned i = 2; i < NPRE; i++) begin
                            prod[i] <= prod[i-1];
                        end
                    end
                end

                assign p_fin = prod[NPRE-1];
            end
        end

        if (ACC_MODE != 0) begin : g_acc
            logic signed [AW-1:0] acc;
            logic signed [AW-1:0] sum;
            logic                 fresh;

            assign sum = fresh ? AW'(p_fin) : acc + AW'(p_fin);

            // Accumulator: restarts on the first beat of a burst, closes on in_last.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    acc   <= '0;
                    fresh <= 1'b1;
                end else if (en && v_fin) begin
                    acc   <= sum;
                    fresh <= l_fin;
                end
            end

            assign exact = sum;
            assign emit  = v_fin && l_fin;
        end else begin : g_plain
            assign exact = p_fin;
            assign emit  = v_fin;
        end
    endgenerate

    logic signed [CW-1:0]    x;
    logic [dout_WIDTH-1:0]   red;
    logic                    red_ovf;

    // Output reduction: range check, then wrap or clamp.
    always_comb begin
        x       = CW'(exact);
        red_ovf = (x > HI) || (x < LO);
        red     = x[dout_WIDTH-1:0];
`ifdef MUL_PIPE_SAT_EN
        if (x > HI) begin
            red = HI[dout_WIDTH-1:0];
        end else if (x < LO) begin
            red = LO[dout_WIDTH-1:0];
        end
`endif
    end

    // Output register: holds under backpressure, reloads on the same edge it is taken.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            dout      <= '0;
        end else if (en) begin
            out_valid <= emit;
            if (emit) begin
                dout     <= red;
                ovf      <= red_ovf;
                out_last <= l_fin;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Randomized bench for myproject_mul_pipe: plain, accumulate and
// unsigned-by-unsigned instances checked against a behavioural model.
module tb_myproject_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Interpret raw bits as a w-bit signed or unsigned integer.
    function automatic longint sx(input longint raw, input int w, input bit sgn);
        longint r;
        r = raw & ((longint'(1) << w) - 1);
        if (sgn && r[w-1]) return r - (longint'(1) << w);
        return r;
    endfunction

    function automatic longint lim_hi(input int dw, input bit rs);
        return rs ? (longint'(1) << (dw - 1)) - 1 : (longint'(1) << dw) - 1;
    endfunction

    function automatic longint lim_lo(input int dw, input bit rs);
        return rs ? -(longint'(1) << (dw - 1)) : 0;
    endfunction

    function automatic longint exp_ovf(input longint v, input int dw, input bit rs);
        return (v > lim_hi(dw, rs) || v < lim_lo(dw, rs)) ? 1 : 0;
    endfunction

    function automatic longint exp_dout(input longint v, input int dw, input bit rs);
        longint r;
        r = v;
`ifdef MUL_PIPE_SAT_EN
        if (v > lim_hi(dw, rs)) r = lim_hi(dw, rs);
        else if (v < lim_lo(dw, rs)) r = lim_lo(dw, rs);
`endif
        return r & ((longint'(1) << dw) - 1);
    endfunction

    typedef struct {
        longint d;
        longint o;
        longint l;
    } exp_t;

    // ---------------- plain instance (defaults) ----------------
    logic        p_rst_n, p_in_valid, p_in_ready, p_in_last;
    logic        p_out_valid, p_out_ready, p_out_last, p_ovf;
    logic [9:0]  p_din0;
    logic [7:0]  p_din1;
    logic [17:0] p_dout;

    myproject_mul_pipe #(.ID(1)) u_plain (
        .ap_clk(clk), .ap_rst_n(p_rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .din0(p_din0), .din1(p_din1), .in_last(p_in_last),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .dout(p_dout), .out_last(p_out_last), .ovf(p_ovf)
    );

    // ---------------- accumulate instance ----------------
    logic        a_rst_n, a_in_valid, a_in_ready, a_in_last;
    logic        a_out_valid, a_out_ready, a_out_last, a_ovf;
    logic [9:0]  a_din0;
    logic [7:0]  a_din1;
    logic [17:0] a_dout;

    myproject_mul_pipe #(.ID(2), .ACC_MODE(1)) u_acc (
        .ap_clk(clk), .ap_rst_n(a_rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din0(a_din0), .din1(a_din1), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .dout(a_dout), .out_last(a_out_last), .ovf(a_ovf)
    );

    // ---------------- unsigned x unsigned instance ----------------
    logic        u_rst_n, u_in_valid, u_in_ready, u_in_last;
    logic        u_out_valid, u_out_ready, u_out_last, u_ovf;
    logic [9:0]  u_din0;
    logic [8:0]  u_din1;
    logic [17:0] u_dout;

    myproject_mul_pipe #(.ID(3), .din1_WIDTH(9), .din1_SIGNED(0)) u_uns (
        .ap_clk(clk), .ap_rst_n(u_rst_n),
        .in_valid(u_in_valid), .in_ready(u_in_ready),
        .din0(u_din0), .din1(u_din1), .in_last(u_in_last),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .dout(u_dout), .out_last(u_out_last), .ovf(u_ovf)
    );

    // Scoreboard for the plain instance: one expected result per accepted beat.
    exp_t p_q[$];
    int   p_outs = 0;
    always @(negedge clk) begin
        exp_t   e;
        longint v;
        if (!p_rst_n) begin
            p_q.delete();
        end else begin
            if (p_in_valid && p_in_ready) begin
                v   = sx(longint'(p_din0), 10, 1'b0) * sx(longint'(p_din1), 8, 1'b1);
                e.d = exp_dout(v, 18, 1'b1);
                e.o = exp_ovf(v, 18, 1'b1);
                e.l = longint'(p_in_last);
                p_q.push_back(e);
            end
            if (p_out_valid && p_out_ready) begin
                p_outs++;
                check("plain_out_expected", longint'(p_q.size() > 0), 1);
                if (p_q.size() > 0) begin
                    e = p_q.pop_front();
                    check("plain_dout", longint'(p_dout), e.d);
                    check("plain_ovf", longint'(p_ovf), e.o);
                    check("plain_last", longint'(p_out_last), e.l);
                end
            end
        end
    end

    // Scoreboard for the accumulate instance: burst sums, one result per in_last.
    exp_t   a_q[$];
    int     a_outs  = 0;
    bit     a_fresh = 1'b1;
    longint a_acc   = 0;
    always @(negedge clk) begin
        exp_t   e;
        longint v;
        if (!a_rst_n) begin
            a_fresh = 1'b1;
            a_acc   = 0;
            a_q.delete();
        end else begin
            if (a_in_valid && a_in_ready) begin
                v       = sx(longint'(a_din0), 10, 1'b0) * sx(longint'(a_din1), 8, 1'b1);
                a_acc   = a_fresh ? v : a_acc + v;
                a_fresh = a_in_last;
                if (a_in_last) begin
                    e.d = exp_dout(a_acc, 18, 1'b1);
                    e.o = exp_ovf(a_acc, 18, 1'b1);
                    e.l = 1;
                    a_q.push_back(e);
                end
            end
            if (a_out_valid && a_out_ready) begin
                a_outs++;
                check("acc_out_expected", longint'(a_q.size() > 0), 1);
                if (a_q.size() > 0) begin
                    e = a_q.pop_front();
                    check("acc_dout", longint'(a_dout), e.d);
                    check("acc_ovf", longint'(a_ovf), e.o);
                    check("acc_last", longint'(a_out_last), e.l);
                end
            end
        end
    end

    logic [9:0] corner0 [5] = '{10'd0, 10'd1023, 10'd1023, 10'd0, 10'd512};
    logic [7:0] corner1 [5] = '{8'd0, 8'd127, 8'h80, 8'h80, 8'hFF};

    initial begin
        int          n;
        int          cnt;
        int          bad;
        int          blen;
        logic [17:0] held;
        logic        held_ovf;
        logic        held_last;

        p_rst_n = 1'b0; a_rst_n = 1'b0; u_rst_n = 1'b0;
        p_in_valid = 1'b0; a_in_valid = 1'b0; u_in_valid = 1'b0;
        p_in_last = 1'b0; a_in_last = 1'b0; u_in_last = 1'b0;
        p_din0 = '0; p_din1 = '0; a_din0 = '0; a_din1 = '0; u_din0 = '0; u_din1 = '0;
        p_out_ready = 1'b0; a_out_ready = 1'b0; u_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        p_rst_n = 1'b1; a_rst_n = 1'b1; u_rst_n = 1'b1;

        // Reset state (out_ready low, so in_ready reflects !out_valid)
        check("rst_out_valid", longint'(p_out_valid), 0);
        check("rst_in_ready", longint'(p_in_ready), 1);
        check("rst_dout", longint'(p_dout), 0);
        check("rst_ovf", longint'(p_ovf), 0);
        check("rst_out_last", longint'(p_out_last), 0);
        check("rst_acc_out_valid", longint'(a_out_valid), 0);
        check("rst_uns_out_valid", longint'(u_out_valid), 0);
        p_out_ready = 1'b1; a_out_ready = 1'b1; u_out_ready = 1'b1;

        // Single beat 1023 x -128, latency counted in edges after driving
        p_din0 = 10'd1023; p_din1 = 8'h80; p_in_last = 1'b1; p_in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            p_in_valid = 1'b0;
        end while (!p_out_valid && n < 10);
        check("plain_latency", n, 3);
        check("plain_first_dout", sx(longint'(p_dout), 18, 1'b1), -130944);
        check("plain_first_ovf", longint'(p_ovf), 0);
        check("plain_first_last", longint'(p_out_last), 1);
        repeat (2) @(posedge clk); #1;

        // Back-to-back stream of 16 beats, corners first
        cnt = 0;
        n   = p_outs;
        for (int i = 0; i < 16; i++) begin
            p_in_valid = 1'b1;
            p_din0     = (i < 5) ? corner0[i] : 10'($urandom);
            p_din1     = (i < 5) ? corner1[i] : 8'($urandom);
            p_in_last  = 1'($urandom);
            if (!p_in_ready) cnt++;
            @(posedge clk); #1;
        end
        p_in_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("stream_in_ready_low", cnt, 0);
        check("stream_outputs", p_outs - n, 16);

        // Backpressure: hold the output for 5 cycles while inputs keep coming
        p_out_ready = 1'b0;
        p_in_valid  = 1'b1;
        n = 0;
        while (!p_out_valid && n < 10) begin
            p_din0 = 10'($urandom); p_din1 = 8'($urandom); p_in_last = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", longint'(p_out_valid), 1);
        held = p_dout; held_ovf = p_ovf; held_last = p_out_last;
        cnt = 0; bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (p_in_ready) cnt++;
            if (!p_out_valid || p_dout != held || p_ovf != held_ovf || p_out_last != held_last) bad++;
            p_din0 = 10'($urandom); p_din1 = 8'($urandom);
            @(posedge clk); #1;
        end
        check("bp_in_ready_high", cnt, 0);
        check("bp_output_moved", bad, 0);
        p_out_ready = 1'b1;
        p_in_valid  = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("bp_drain_left", p_q.size(), 0);

        // Random valid/ready traffic on the plain instance
        for (int i = 0; i < 300; i++) begin
            p_in_valid  = 1'($urandom);
            p_din0      = 10'($urandom);
            p_din1      = 8'($urandom);
            p_in_last   = 1'($urandom);
            p_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        p_in_valid  = 1'b0;
        p_out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("plain_random_left", p_q.size(), 0);

        // Accumulate: 4 x (1023 x -128), last on the 4th
        n = a_outs;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_din0 = 10'd1023; a_din1 = 8'h80; a_in_last = (i == 3);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        cnt = 0;
        while (!a_out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("acc4_valid", longint'(a_out_valid), 1);
`ifdef MUL_PIPE_SAT_EN
        check("acc4_dout", sx(longint'(a_dout), 18, 1'b1), -131072);
`else
        check("acc4_dout", sx(longint'(a_dout), 18, 1'b1), 512);
`endif
        check("acc4_ovf", longint'(a_ovf), 1);
        check("acc4_last", longint'(a_out_last), 1);
        repeat (3) @(posedge clk); #1;
        check("acc4_count", a_outs - n, 1);

        // Reset in the middle of a burst
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_din0 = 10'd7; a_din1 = 8'd5; a_in_last = 1'b0;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        check("acc_rst_out_valid", longint'(a_out_valid), 0);
        check("acc_rst_in_ready", longint'(a_in_ready), 1);
        a_in_valid = 1'b1; a_din0 = 10'd2; a_din1 = 8'd3; a_in_last = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        cnt = 0;
        while (!a_out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("acc_rst_valid", longint'(a_out_valid), 1);
        check("acc_rst_dout", sx(longint'(a_dout), 18, 1'b1), 6);
        check("acc_rst_last", longint'(a_out_last), 1);
        check("acc_rst_ovf", longint'(a_ovf), 0);
        repeat (2) @(posedge clk); #1;

        // Random bursts with random backpressure
        blen = 0;
        for (int i = 0; i < 300; i++) begin
            a_in_valid  = 1'($urandom);
            a_din0      = 10'($urandom);
            a_din1      = 8'($urandom);
            a_in_last   = (i == 299) || (blen >= 20) || ($urandom_range(0, 3) == 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (a_in_valid && a_in_ready) blen = a_in_last ? 0 : blen + 1;
            @(posedge clk); #1;
        end
        a_in_valid  = 1'b1;
        a_in_last   = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("acc_random_left", a_q.size(), 0);

        // Unsigned x unsigned: in range, then overflow
        u_din0 = 10'd1023; u_din1 = 9'd255; u_in_last = 1'b1; u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        cnt = 0;
        while (!u_out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("uu_valid", longint'(u_out_valid), 1);
        check("uu_dout", longint'(u_dout), 260865);
        check("uu_ovf", longint'(u_ovf), 0);
        @(posedge clk); #1;
        u_din0 = 10'd1023; u_din1 = 9'd257; u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        cnt = 0;
        while (!u_out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("uu_big_valid", longint'(u_out_valid), 1);
`ifdef MUL_PIPE_SAT_EN
        check("uu_big_dout", longint'(u_dout), 262143);
`else
        check("uu_big_dout", longint'(u_dout), 767);
`endif
        check("uu_big_ovf", longint'(u_ovf), 1);
        check("uu_big_last", longint'(u_out_last), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
